seq_shifter: RTL and testbench
==============================

Name: seq_shifter

Overview:
- Parametrised multi-cycle shift/rotate unit for the Mini-SRC datapath ALU.
- Generalises the single combinational right-shift block: five operations, configurable word width and configurable bits shifted per clock.
- Uses a start/busy/done handshake, so long shifts do not create a deep combinational loop.
- The ALU controller starts an operation, waits for done, and then latches result into Z.

Parameters:
- WIDTH, 32: data width. Must be a power of 2, at least 8.
- STEP, 1: maximum bits shifted per clock. Power of 2, from 1 to WIDTH.
- CNT_W, $clog2(WIDTH)+1: width of the internal remaining-count register.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear_n  in  1  synchronous active-low reset.
- start  in  1  request. Sampled only when the block is not busy.
- op  in  3  operation: 0 SHR, 1 SHRA, 2 SHL, 3 ROR, 4 ROL, 5-7 illegal.
- a  in  WIDTH  operand, captured on accept.
- amt  in  WIDTH  shift amount, unsigned, captured on accept.
- busy  out  1  high while in state SHIFT.
- done  out  1  one-cycle pulse; result valid while done is high.
- result  out  WIDTH  working register; holds the final value until the next accept.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset: when clear_n=0 at a rising edge, state goes to IDLE and busy=0, done=0, result=0. This holds even mid-operation; the operation in progress is dropped and no done is issued.
- States: IDLE, SHIFT, DONE. busy = (state==SHIFT).
- Accept: start=1 in IDLE or DONE at edge E0.
  - a is loaded into result.
  - The effective count n is loaded into the remaining-count register.
  - If n>0, go to SHIFT; if n==0, go to DONE.
  - start while in SHIFT is ignored; no queuing.
- Effective count n:
  - SHR, SHL, SHRA: n = min(amt, WIDTH).
  - ROR, ROL: n = amt mod WIDTH.
  - Ops 5-7: n = 0, so result = a unchanged.
- SHIFT: each edge shifts by k = min(STEP, remaining) and decrements remaining by k. When remaining reaches 0, go to DONE.
- Fill rules:
  - SHR and SHL fill with 0.
  - SHRA fills with the MSB of the operand as captured at accept.
  - Rotates wrap bits around.
  - A shift of WIDTH therefore gives 0 for SHR/SHL and all-sign for SHRA.
- Latency: done rises at edge E0 + ceil(n/STEP). It is high for exactly one cycle; DONE then moves to IDLE unless start is asserted.
- Back-to-back: a start asserted during the done cycle is accepted, with zero bubble.
- result: intermediate while busy; stable from done until the next accept.

Optional Feature:
- Macro: SEQ_SHIFTER_BARREL_EN.
- Defined:
  - SHIFT completes any n>0 in one edge, using a full log-stage barrel shifter.
  - STEP is ignored.
  - done rises at E0+1, or at E0 when n=0.
- Undefined: iterative STEP-per-cycle datapath as above.
- Effective-count, fill, handshake and reset rules are identical in both builds.

Decomposition:
- Package shifter_pkg contains:
  - shift_op_t enum (SHR, SHRA, SHL, ROR, ROL) with encodings 0-4.
  - seq_state_t enum (IDLE, SHIFT, DONE).
  - Function eff_count(op, amt, width).
- Sub-module shift_step: combinational shift of a value by k bits, where 0 ≤ k ≤ STEP, for a given op and fill bit.
  - Instantiated once in the iterative build.
  - The barrel build instantiates it with STEP=WIDTH.

Test Plan:
- WIDTH=32, STEP=1, SHR: a=0x80000000, amt=4 → result=0x08000000; busy high for 4 cycles; done pulses at E0+4.
- SHRA: a=0x80000000, amt=35 → n=32; result=0xFFFFFFFF at E0+32.
- ROL: a=0x80000001, amt=33 → n=1; result=0x00000003 at E0+1.
- SHL: amt=0 → result=a, done at E0; op=6 → result=a, done at E0.
- STEP=4, SHL: a=0x1, amt=9 → result=0x00000200 after 3 SHIFT cycles (4+4+1); done at E0+3.
- Reset and handshake:
  - clear_n=0 at E0+2 of a 10-bit SHR → busy=0, done=0, result=0; no done pulse follows.
  - start held during SHIFT is ignored.
  - start asserted during the done cycle is accepted immediately.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and effective-count helper for the sequential shifter.
// Used by seq_shifter and shift_step.
package shifter_pkg;

  typedef enum logic [2:0] {
    SHR  = 3'd0,
    SHRA = 3'd1,
    SHL  = 3'd2,
    ROR  = 3'd3,
    ROL  = 3'd4
  } shift_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  // Logical/arithmetic shifts saturate at width; rotates wrap modulo width.
  function automatic logic [31:0] eff_count(
    input shift_op_t   op,
    input logic [63:0] amt,
    input int unsigned width
  );
    logic [63:0] w;
    logic [31:0] n;
    w = 64'(width);
    n = '0;
    case (op)
      SHR, SHRA, SHL: n = (amt >= w) ? width[31:0] : amt[31:0];
      ROR, ROL:       n = 32'(amt & (w - 64'd1));
      default:        n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/shift_step.sv
// Combinational shift/rotate of a word by k bits, 0 <= k <= STEP.
// One log stage per bit of k; SHR and SHL always fill with zero.
module shift_step
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  localparam int KW   = $clog2(STEP) + 1
) (
  input  logic [WIDTH-1:0] value,
  input  logic [KW-1:0]    k,
  input  shift_op_t        op,
  input  logic             fill,
  output logic [WIDTH-1:0] shifted
);

  function automatic logic [WIDTH-1:0] stage(
    input logic [WIDTH-1:0] v,
    input int               s,
    input shift_op_t        o,
    input logic             f
  );
    logic [WIDTH-1:0] r;
    r = v;
    case (o)
      SHR:     r = v >> s;
      SHRA:    r = f ? ~(~v >> s) : (v >> s);
      SHL:     r = v << s;
      ROR:     r = (v >> s) | (v << (WIDTH - s));
      ROL:     r = (v << s) | (v >> (WIDTH - s));
      default: r = v;
    endcase
    return r;
  endfunction

  always_comb begin
    shifted = value;
    for (int i = 0; i < KW; i++) begin
      if (k[i]) shifted = stage(shifted, 1 << i, op, fill);
    end
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit with start/busy/done handshake.
// SEQ_SHIFTER_BARREL_EN: finish any shift in a single SHIFT cycle.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 1,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             clear_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

`ifdef SEQ_SHIFTER_BARREL_EN
  localparam int SW = WIDTH;
`else
  localparam int SW = STEP;
`endif
  localparam int KW = $clog2(SW) + 1;

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] res_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] rem_dec;
  logic [CNT_W-1:0] n;
  shift_op_t        op_q, op_d;
  logic             fill_q, fill_d;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] shifted;
  logic             accept;

  assign n = CNT_W'(eff_count(shift_op_t'(op), 64'(amt), WIDTH));

  always_comb begin
    if (rem_q >= CNT_W'(SW)) k = KW'(SW);
    else                     k = rem_q[KW-1:0];
  end

  assign rem_dec = rem_q - CNT_W'(k);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (SW)
  ) u_step (
    .value   (result),
    .k       (k),
    .op      (op_q),
    .fill    (fill_q),
    .shifted (shifted)
  );

  assign accept = start && (state_q != SHIFT);

  always_comb begin
    state_d = state_q;
    res_d   = result;
    rem_d   = rem_q;
    op_d    = op_q;
    fill_d  = fill_q;
    unique case (1'b1)
      accept: begin
        res_d   = a;
        rem_d   = n;
        op_d    = shift_op_t'(op);
        fill_d  = a[WIDTH-1];
        state_d = (n != '0) ? SHIFT : DONE;
      end
      (state_q == SHIFT): begin
        res_d   = shifted;
        rem_d   = rem_dec;
        state_d = (rem_dec == '0) ? DONE : SHIFT;
      end
      (state_q == DONE && !start): begin
        state_d = IDLE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!clear_n) begin
      state_q <= IDLE;
      result  <= '0;
      rem_q   <= '0;
      op_q    <= SHR;
      fill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      result  <= res_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      fill_q  <= fill_d;
    end
  end

  assign busy = (state_q == SHIFT);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: STEP=1 and STEP=4 instances
// sharing inputs, checked on the falling edge.
module tb_seq_shifter;

  logic        clock = 1'b0;
  logic        clear_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] amt;
  logic        busy1, done1, busy4, done4;
  logic [31:0] result1, result4;
  logic        sel;
  logic        busy_m, done_m;
  logic [31:0] res_m;
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  assign busy_m = sel ? busy4 : busy1;
  assign done_m = sel ? done4 : done1;
  assign res_m  = sel ? result4 : result1;

  seq_shifter #(.WIDTH(32), .STEP(1)) u_dut1 (
    .clock   (clock),
    .clear_n (clear_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .amt     (amt),
    .busy    (busy1),
    .done    (done1),
    .result  (result1)
  );

  seq_shifter #(.WIDTH(32), .STEP(4)) u_dut4 (
    .clock   (clock),
    .clear_n (clear_n),
    .start   (start),
    .op      (op),
    .a       (a),
    .amt     (amt),
    .busy    (busy4),
    .done    (done4),
    .result  (result4)
  );

  function automatic int exp_lat(input int n, input int step);
`ifdef SEQ_SHIFTER_BARREL_EN
    return (n > 0) ? 1 : 0;
`else
    return (n + step - 1) / step;
`endif
  endfunction

  // Called on a falling edge; returns on the falling edge where done is seen.
  task automatic run(
    input  logic [2:0]  o,
    input  logic [31:0] av,
    input  logic [31:0] am,
    input  bit          hold,
    output int          lat,
    output int          bcyc
  );
    start = 1'b1;
    op    = o;
    a     = av;
    amt   = am;
    @(negedge clock);
    if (!hold) start = 1'b0;
    lat  = 0;
    bcyc = 0;
    while (!done_m && lat < 200) begin
      if (busy_m) bcyc++;
      @(negedge clock);
      lat++;
    end
    if (!done_m) lat = -1;
  endtask

  task automatic pulse_reset();
    start   = 1'b0;
    clear_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    clear_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    start   = 1'b0;
    op      = 3'd0;
    a       = '0;
    amt     = '0;
    sel     = 1'b0;
    clear_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (busy1 !== 1'b0) begin
      failures++; $display("FAIL reset_busy1 got=%b exp=0", busy1);
    end
    checks++;
    if (done1 !== 1'b0) begin
      failures++; $display("FAIL reset_done1 got=%b exp=0", done1);
    end
    checks++;
    if (result1 !== 32'h0) begin
      failures++; $display("FAIL reset_result1 got=%h exp=0", result1);
    end
    checks++;
    if (busy4 !== 1'b0 || done4 !== 1'b0) begin
      failures++; $display("FAIL reset_flags4 got=%b%b exp=00", busy4, done4);
    end
    checks++;
    if (result4 !== 32'h0) begin
      failures++; $display("FAIL reset_result4 got=%h exp=0", result4);
    end
    clear_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_shr();
    int lat, bc;
    sel = 1'b0;
    run(3'd0, 32'h8000_0000, 32'd4, 1'b0, lat, bc);
    checks++;
    if (res_m !== 32'h0800_0000) begin
      failures++; $display("FAIL shr_result got=%h exp=08000000", res_m);
    end
    checks++;
    if (lat !== exp_lat(4, 1)) begin
      failures++; $display("FAIL shr_latency got=%0d exp=%0d", lat, exp_lat(4, 1));
    end
    checks++;
    if (bc !== exp_lat(4, 1)) begin
      failures++; $display("FAIL shr_busy_cycles got=%0d exp=%0d", bc, exp_lat(4, 1));
    end
    @(negedge clock);
    checks++;
    if (done_m !== 1'b0 || busy_m !== 1'b0 || res_m !== 32'h0800_0000) begin
      failures++;
      $display("FAIL shr_after_done got=%b%b/%h exp=00/08000000", done_m, busy_m, res_m);
    end
  endtask

  task automatic test_shra();
    int lat, bc;
    sel = 1'b0;
    run(3'd1, 32'h8000_0000, 32'd35, 1'b0, lat, bc);
    checks++;
    if (res_m !== 32'hFFFF_FFFF) begin
      failures++; $display("FAIL shra_result got=%h exp=ffffffff", res_m);
    end
    checks++;
    if (lat !== exp_lat(32, 1)) begin
      failures++; $display("FAIL shra_latency got=%0d exp=%0d", lat, exp_lat(32, 1));
    end
    run(3'd2, 32'hFFFF_FFFF, 32'd32, 1'b0, lat, bc);
    checks++;
    if (res_m !== 32'h0) begin
      failures++; $display("FAIL shl_full_result got=%h exp=0", res_m);
    end
  endtask

  task automatic test_rotate();
    int lat, bc;
    sel = 1'b0;
    run(3'd4, 32'h8000_0001, 32'd33, 1'b0, lat, bc);
    checks++;
    if (res_m !== 32'h0000_0003) begin
      failures++; $display("FAIL rol_result got=%h exp=00000003", res_m);
    end
    checks++;
    if (lat !== exp_lat(1, 1)) begin
      failures++; $display("FAIL rol_latency got=%0d exp=%0d", lat, exp_lat(1, 1));
    end
    run(3'd3, 32'h1234_5678, 32'd4, 1'b0, lat, bc);
    checks++;
    if (res_m !== 32'h8123_4567) begin
      failures++; $display("FAIL ror_result got=%h exp=81234567", res_m);
    end
  endtask

  task automatic test_zero();
    int lat, bc;
    sel = 1'b0;
    run(3'd2, 32'hDEAD_BEEF, 32'd0, 1'b0, lat, bc);
    checks++;
    if (res_m !== 32'hDEAD_BEEF || lat !== 0) begin
      failures++; $display("FAIL shl_zero got=%h/%0d exp=deadbeef/0", res_m, lat);
    end
    checks++;
    if (bc !== 0) begin
      failures++; $display("FAIL shl_zero_busy got=%0d exp=0", bc);
    end
    run(3'd6, 32'h1234_5678, 32'd5, 1'b0, lat, bc);
    checks++;
    if (res_m !== 32'h1234_5678) begin
      failures++; $display("FAIL illegal_result got=%h exp=12345678", res_m);
    end
    checks++;
    if (lat !== 0) begin
      failures++; $display("FAIL illegal_latency got=%0d exp=0", lat);
    end
  endtask

  task automatic test_step4();
    int lat, bc;
    pulse_reset();
    sel = 1'b1;
    run(3'd2, 32'h0000_0001, 32'd9, 1'b0, lat, bc);
    checks++;
    if (res_m !== 32'h0000_0200) begin
      failures++; $display("FAIL step4_shl_result got=%h exp=00000200", res_m);
    end
    checks++;
    if (lat !== exp_lat(9, 4) || bc !== exp_lat(9, 4)) begin
      failures++;
      $display("FAIL step4_shl_latency got=%0d/%0d exp=%0d", lat, bc, exp_lat(9, 4));
    end
    run(3'd3, 32'h1234_5678, 32'd8, 1'b0, lat, bc);
    checks++;
    if (res_m !== 32'h7812_3456 || lat !== exp_lat(8, 4)) begin
      failures++;
      $display("FAIL step4_ror got=%h/%0d exp=78123456/%0d", res_m, lat, exp_lat(8, 4));
    end
    run(3'd1, 32'h4000_0000, 32'd40, 1'b0, lat, bc);
    checks++;
    if (res_m !== 32'h0 || lat !== exp_lat(32, 4)) begin
      failures++;
      $display("FAIL step4_shra_pos got=%h/%0d exp=0/%0d", res_m, lat, exp_lat(32, 4));
    end
    @(negedge clock);
  endtask

  task automatic test_hold_start();
    int lat, bc;
    pulse_reset();
    sel = 1'b0;
    run(3'd0, 32'h0000_00F0, 32'd4, 1'b1, lat, bc);
    start = 1'b0;
    checks++;
    if (res_m !== 32'h0000_000F) begin
      failures++; $display("FAIL hold_result got=%h exp=0000000f", res_m);
    end
    checks++;
    if (lat !== exp_lat(4, 1)) begin
      failures++; $display("FAIL hold_latency got=%0d exp=%0d", lat, exp_lat(4, 1));
    end
    @(negedge clock);
    checks++;
    if (busy_m !== 1'b0 || done_m !== 1'b0 || res_m !== 32'h0000_000F) begin
      failures++;
      $display("FAIL hold_idle got=%b%b/%h exp=00/0000000f", busy_m, done_m, res_m);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    sel = 1'b0;
    run(3'd0, 32'h0000_0100, 32'd2, 1'b0, lat, bc);
    checks++;
    if (res_m !== 32'h0000_0040 || lat !== exp_lat(2, 1)) begin
      failures++;
      $display("FAIL b2b_first got=%h/%0d exp=00000040/%0d", res_m, lat, exp_lat(2, 1));
    end
    run(3'd2, 32'h0000_0003, 32'd3, 1'b0, lat, bc);
    checks++;
    if (res_m !== 32'h0000_0018) begin
      failures++; $display("FAIL b2b_second_result got=%h exp=00000018", res_m);
    end
    checks++;
    if (lat !== exp_lat(3, 1)) begin
      failures++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat, exp_lat(3, 1));
    end
    checks++;
    if (bc !== exp_lat(3, 1)) begin
      failures++; $display("FAIL b2b_busy_cycles got=%0d exp=%0d", bc, exp_lat(3, 1));
    end
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int dcount;
    sel     = 1'b0;
    start   = 1'b1;
    op      = 3'd0;
    a       = 32'h0000_03FF;
    amt     = 32'd10;
    @(negedge clock);
    start   = 1'b0;
    checks++;
    if (busy_m !== 1'b1) begin
      failures++; $display("FAIL mid_busy_before got=%b exp=1", busy_m);
    end
    @(negedge clock);
    clear_n = 1'b0;
    @(negedge clock);
    clear_n = 1'b1;
    checks++;
    if (busy_m !== 1'b0 || done_m !== 1'b0) begin
      failures++; $display("FAIL mid_reset_flags got=%b%b exp=00", busy_m, done_m);
    end
    checks++;
    if (res_m !== 32'h0) begin
      failures++; $display("FAIL mid_reset_result got=%h exp=0", res_m);
    end
    dcount = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (done_m) dcount++;
    end
    checks++;
    if (dcount !== 0) begin
      failures++; $display("FAIL mid_no_done got=%0d exp=0", dcount);
    end
  endtask

  initial begin
    test_reset();
    test_shr();
    test_shra();
    test_rotate();
    test_zero();
    test_step4();
    test_hold_start();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
